// File: rtl/dilithium_pkg.sv
// rtl/dilithium_pkg.sv - Dilithium constants, INTT state encoding and the plain-domain zeta table
package dilithium_pkg;

    localparam logic [22:0] Q             = 23'd8380417;
    localparam logic [22:0] N_INV         = 23'd8347681;
    localparam logic [22:0] ROOT_OF_UNITY = 23'd1753;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LOOP,
        ST_START_LOOP,
        ST_J_READ,
        ST_J_WRITE,
        ST_SCALE_READ,
        ST_SCALE_WRITE,
        ST_DONE
    } intt_state_e;

    typedef logic [255:0][22:0] zeta_table_t;

    // zeta[k] = 1753^bitrev8(k) mod q, built by square-and-multiply at elaboration
    function automatic zeta_table_t gen_zetas();
        zeta_table_t tbl;
        logic [63:0] acc;
        logic [63:0] base;
        logic [7:0]  kk;
        logic [7:0]  e;
        tbl = '0;
        for (int k = 0; k < 256; k++) begin
            kk   = k[7:0];
            e    = {kk[0], kk[1], kk[2], kk[3], kk[4], kk[5], kk[6], kk[7]};
            acc  = 64'd1;
            base = 64'(ROOT_OF_UNITY);
            for (int b = 0; b < 8; b++) begin
                if (e[0]) begin
                    acc = (acc * base) % 64'(Q);
                end
                base = (base * base) % 64'(Q);
                e    = e >> 1;
            end
            tbl[kk] = 23'(acc);
        end
        return tbl;
    endfunction

    localparam zeta_table_t ZETAS = gen_zetas();

endpackage

// File: rtl/dilithium_zeta_rom.sv
// rtl/dilithium_zeta_rom.sv - combinational 256x23 zeta lookup shared by forward and inverse NTT
module dilithium_zeta_rom
    import dilithium_pkg::*;
(
    input  logic [7:0]  idx_i,
    output logic [22:0] zeta_o
);

    assign zeta_o = ZETAS[idx_i];

endmodule

// File: rtl/intt_fsm.sv
// rtl/intt_fsm.sv - inverse NTT controller: in-place Gentleman-Sande butterflies, then n^-1 scale pass
module intt_fsm
    import dilithium_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_intt,
    input  logic [23:0]       Q0,
    input  logic [23:0]       Q1,
    input  logic [22:0]       reduction_output0,
    input  logic [22:0]       reduction_output1,
    input  logic [22:0]       reduction_output2,
    output logic              busy,
    output logic              done_intt,
    output logic [ADDR_W-1:0] A0,
    output logic [ADDR_W-1:0] A1,
    output logic [23:0]       D0,
    output logic [23:0]       D1,
    output logic              WEB0,
    output logic              WEB1,
    output logic [45:0]       reduction_input0,
    output logic [45:0]       reduction_input1,
    output logic [45:0]       reduction_input2
);

    intt_state_e       state_q, state_d;
    logic [8:0]        len_q, len_d;
    logic [8:0]        start_q, start_d;
    logic [8:0]        k_q, k_d;
    logic [7:0]        j_q, j_d;
    logic [6:0]        i_q, i_d;
    logic [22:0]       zinv_q, zinv_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] a0_q, a1_q;

    logic [22:0] zeta;
    logic [7:0]  zeta_idx;
    logic [22:0] q0_v, q1_v;
    logic [8:0]  j_upper;
    logic        j_last;
    logic        in_bf, in_scale;
    logic [45:0] bf_sum, bf_diff, bf_twiddle, sc_hi, sc_lo;
    logic        unused_msb;

    assign q0_v       = Q0[22:0];
    assign q1_v       = Q1[22:0];
    assign unused_msb = Q0[23] ^ Q1[23];

    assign zeta_idx = 8'(k_q - 9'd1);

    dilithium_zeta_rom u_zeta_rom (
        .idx_i  (zeta_idx),
        .zeta_o (zeta)
    );

    assign j_upper = {1'b0, j_q} + len_q;
    assign j_last  = ({1'b0, j_q} + 9'd1) == (start_q + len_q);

    // Butterfly and scale operands are kept as separate assigns so the twiddle
    // product can follow reduction_output1 without a false combinational loop.
    assign in_bf      = (state_q == ST_J_WRITE);
    assign in_scale   = (state_q == ST_SCALE_READ) || (state_q == ST_SCALE_WRITE);
    assign bf_sum     = 46'(q1_v) + 46'(q0_v);
    assign bf_diff    = 46'(q1_v) + 46'(Q) - 46'(q0_v);
    assign bf_twiddle = 46'(reduction_output1) * 46'(zinv_q);
    assign sc_hi      = 46'(q1_v) * 46'(N_INV);
    assign sc_lo      = 46'(q0_v) * 46'(N_INV);

    assign reduction_input0 = in_scale ? sc_hi : (in_bf ? bf_sum : '0);
    assign reduction_input1 = in_bf ? bf_diff : '0;
    assign reduction_input2 = in_scale ? sc_lo : (in_bf ? bf_twiddle : '0);

    assign D1 = {1'b0, reduction_output0};
    assign D0 = {1'b0, reduction_output2};

    assign busy      = (state_q != ST_IDLE);
    assign done_intt = done_q;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        start_d = start_q;
        k_d     = k_q;
        j_d     = j_q;
        i_d     = i_q;
        zinv_d  = zinv_q;
        done_d  = 1'b0;
        A0      = a0_q;
        A1      = a1_q;
        WEB0    = 1'b1;
        WEB1    = 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                if (start_intt) begin
                    state_d = ST_LEN_LOOP;
                    len_d   = 9'd1;
                    k_d     = 9'd256;
                end
            end
            ST_LEN_LOOP: begin
                if (len_q[8]) begin
                    state_d = ST_SCALE_READ;
                    i_d     = '0;
                end else begin
                    state_d = ST_START_LOOP;
                    start_d = '0;
                end
            end
            ST_START_LOOP: begin
                if (!start_q[8]) begin
                    state_d = ST_J_READ;
                    k_d     = k_q - 9'd1;
                    zinv_d  = Q - zeta;
                    j_d     = start_q[7:0];
                end else begin
                    state_d = ST_LEN_LOOP;
                    len_d   = len_q << 1;
                end
            end
            ST_J_READ: begin
                A1      = ADDR_W'(j_q);
                A0      = ADDR_W'(j_upper);
                state_d = ST_J_WRITE;
            end
            ST_J_WRITE: begin
                A1   = ADDR_W'(j_q);
                A0   = ADDR_W'(j_upper);
                WEB0 = 1'b0;
                WEB1 = 1'b0;
                if (j_last) begin
                    start_d = start_q + (len_q << 1);
                    state_d = ST_START_LOOP;
                end else begin
                    j_d     = j_q + 8'd1;
                    state_d = ST_J_READ;
                end
            end
            ST_SCALE_READ: begin
                A1      = ADDR_W'({i_q, 1'b0});
                A0      = ADDR_W'({i_q, 1'b1});
                state_d = ST_SCALE_WRITE;
            end
            ST_SCALE_WRITE: begin
                A1   = ADDR_W'({i_q, 1'b0});
                A0   = ADDR_W'({i_q, 1'b1});
                WEB0 = 1'b0;
                WEB1 = 1'b0;
                if (i_q == 7'd127) begin
                    state_d = ST_DONE;
                end else begin
                    i_d     = i_q + 7'd1;
                    state_d = ST_SCALE_READ;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            len_q   <= 9'd1;
            start_q <= '0;
            k_q     <= 9'd256;
            j_q     <= '0;
            i_q     <= '0;
            zinv_q  <= '0;
            done_q  <= 1'b0;
            a0_q    <= '0;
            a1_q    <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            start_q <= start_d;
            k_q     <= k_d;
            j_q     <= j_d;
            i_q     <= i_d;
            zinv_q  <= zinv_d;
            done_q  <= done_d;
            a0_q    <= A0;
            a1_q    <= A1;
        end
    end

endmodule

// File: tb/tb_intt_fsm.sv
// tb/tb_intt_fsm.sv - self-checking bench for intt_fsm with SRAM and mod-q reducer models
module tb_intt_fsm;

    localparam longint      QM  = 8380417;
    localparam logic [45:0] Q46 = 46'd8380417;

    typedef struct {
        int          kind;      // 0: constant fill, 1: random round trip through forward NTT
        int unsigned seed;
        longint      fill;
        longint      exp0;
        longint      exp_rest;
        bit          poke;      // pulse start_intt while busy
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_intt = 1'b0;
    logic [23:0] Q0, Q1;
    logic [22:0] reduction_output0, reduction_output1, reduction_output2;
    logic        busy, done_intt;
    logic [15:0] A0, A1;
    logic [23:0] D0, D1;
    logic        WEB0, WEB1;
    logic [45:0] reduction_input0, reduction_input1, reduction_input2;

    logic [23:0] mem [256];
    logic        tb_we = 1'b0;
    logic [7:0]  tb_addr = '0;
    logic [23:0] tb_data = '0;
    wire         unused_addr_hi = ^{A0[15:8], A1[15:8]};

    int     n_tests = 0;
    int     n_fail = 0;
    longint zeta_m [256];
    longint a_m [256];
    longint exp_q [$];

    always #5 clk = ~clk;

    intt_fsm #(.ADDR_W(16)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start_intt        (start_intt),
        .Q0                (Q0),
        .Q1                (Q1),
        .reduction_output0 (reduction_output0),
        .reduction_output1 (reduction_output1),
        .reduction_output2 (reduction_output2),
        .busy              (busy),
        .done_intt         (done_intt),
        .A0                (A0),
        .A1                (A1),
        .D0                (D0),
        .D1                (D1),
        .WEB0              (WEB0),
        .WEB1              (WEB1),
        .reduction_input0  (reduction_input0),
        .reduction_input1  (reduction_input1),
        .reduction_input2  (reduction_input2)
    );

    assign reduction_output0 = 23'(reduction_input0 % Q46);
    assign reduction_output1 = 23'(reduction_input1 % Q46);
    assign reduction_output2 = 23'(reduction_input2 % Q46);

    always @(posedge clk) begin
        Q0 <= mem[A0[7:0]];
        Q1 <= mem[A1[7:0]];
        if (tb_we) mem[tb_addr] <= tb_data;
        if (!WEB0) mem[A0[7:0]] <= D0;
        if (!WEB1) mem[A1[7:0]] <= D1;
    end

    task automatic check(input string name, input longint act, input longint req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic fwd_ntt();
        int     k;
        longint t;
        k = 0;
        for (int len = 128; len > 0; len = len >> 1) begin
            for (int start = 0; start < 256; start += 2 * len) begin
                k++;
                for (int j = start; j < start + len; j++) begin
                    t = (zeta_m[k] * a_m[j + len]) % QM;
                    a_m[j + len] = (a_m[j] - t + QM) % QM;
                    a_m[j] = (a_m[j] + t) % QM;
                end
            end
        end
    endtask

    task automatic load_vec(input vec_t v, input bit push);
        longint x [256];
        if (v.kind == 0) begin
            for (int i = 0; i < 256; i++) begin
                a_m[i] = v.fill;
                x[i]   = (i == 0) ? v.exp0 : v.exp_rest;
            end
        end else begin
            void'($urandom(v.seed));
            for (int i = 0; i < 256; i++) begin
                x[i]   = longint'($urandom_range(32'(QM - 1), 0));
                a_m[i] = x[i];
            end
            fwd_ntt();
        end
        if (push) begin
            for (int i = 0; i < 256; i++) exp_q.push_back(x[i]);
        end
        for (int i = 0; i < 256; i++) begin
            tb_we   = 1'b1;
            tb_addr = 8'(i);
            tb_data = 24'(a_m[i]);
            @(posedge clk); #1;
        end
        tb_we = 1'b0;
    endtask

    task automatic run_and_check(input string name, input bit poke);
        int     cnt;
        bit     seen;
        int     bad;
        int     first_bad;
        longint e;
        @(negedge clk);
        start_intt = 1'b1;
        @(posedge clk); #1;
        start_intt = 1'b0;
        check({name, "_busy_start"}, busy, 1);
        cnt  = 1;
        seen = 1'b0;
        while (!seen && cnt < 6000) begin
            @(posedge clk); #1;
            cnt++;
            if (poke) start_intt = (cnt % 300 == 0);
            if (done_intt) seen = 1'b1;
        end
        start_intt = 1'b0;
        check({name, "_latency"}, seen ? cnt : -1, 2578);
        check({name, "_busy_at_done"}, busy, 0);
        @(posedge clk); #1;
        check({name, "_done_width"}, done_intt, 0);
        bad       = 0;
        first_bad = -1;
        for (int i = 0; i < 256; i++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            if (longint'(mem[i]) != e) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
        end
        check($sformatf("%s_image_mismatches(first_idx=%0d)", name, first_bad), bad, 0);
    endtask

    initial begin
        vec_t   vecs [8];
        vec_t   vr;
        int     e, cnt, pulses, first_at, second_at;
        longint r;
        bit     busy_after, busy_late;

        for (int k = 0; k < 256; k++) begin
            e = 0;
            for (int b = 0; b < 8; b++) e = e | (((k >> b) & 1) << (7 - b));
            r = 1;
            for (int p = 0; p < e; p++) r = (r * 1753) % QM;
            zeta_m[k] = r;
        end

        vecs[0] = '{kind: 0, seed: 0,  fill: 1,      exp0: 1,      exp_rest: 0, poke: 0};
        vecs[1] = '{kind: 0, seed: 0,  fill: QM - 1, exp0: QM - 1, exp_rest: 0, poke: 0};
        vecs[2] = '{kind: 0, seed: 0,  fill: 0,      exp0: 0,      exp_rest: 0, poke: 0};
        vecs[3] = '{kind: 0, seed: 0,  fill: 5,      exp0: 5,      exp_rest: 0, poke: 1};
        vecs[4] = '{kind: 1, seed: 11, fill: 0,      exp0: 0,      exp_rest: 0, poke: 0};
        vecs[5] = '{kind: 1, seed: 22, fill: 0,      exp0: 0,      exp_rest: 0, poke: 1};
        vecs[6] = '{kind: 1, seed: 33, fill: 0,      exp0: 0,      exp_rest: 0, poke: 0};
        vecs[7] = '{kind: 1, seed: 44, fill: 0,      exp0: 0,      exp_rest: 0, poke: 0};
        vr      = '{kind: 1, seed: 77, fill: 0,      exp0: 0,      exp_rest: 0, poke: 0};

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done_intt, 0);
        check("reset_web0", WEB0, 1);
        check("reset_web1", WEB1, 1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 8; v++) begin
            load_vec(vecs[v], 1'b1);
            run_and_check($sformatf("vec%0d", v), vecs[v].poke);
        end

        // Mid-run reset during a write cycle, then reload and rerun
        load_vec(vr, 1'b0);
        @(negedge clk);
        start_intt = 1'b1;
        @(posedge clk); #1;
        start_intt = 1'b0;
        repeat (999) @(posedge clk);
        cnt = 0;
        do begin
            @(posedge clk); #2;
            cnt++;
        end while (WEB0 && cnt < 50);
        check("pre_reset_busy", busy, 1);
        check("pre_reset_web0", WEB0, 0);
        rst_n = 1'b0;
        #1;
        check("mid_reset_web0", WEB0, 1);
        check("mid_reset_web1", WEB1, 1);
        check("mid_reset_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        load_vec(vr, 1'b1);
        run_and_check("after_reset", 1'b0);

        // start_intt held high across two back-to-back runs
        load_vec(vecs[0], 1'b0);
        @(negedge clk);
        start_intt = 1'b1;
        pulses     = 0;
        cnt        = 0;
        first_at   = 0;
        second_at  = 0;
        busy_after = 1'b0;
        busy_late  = 1'b0;
        while (pulses < 2 && cnt < 6000) begin
            @(posedge clk); #1;
            cnt++;
            if (pulses == 1 && cnt == first_at + 1) busy_after = busy;
            if (done_intt) begin
                pulses++;
                if (pulses == 1) begin
                    first_at = cnt;
                end else begin
                    second_at  = cnt;
                    start_intt = 1'b0;
                end
            end
        end
        start_intt = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done_intt) pulses++;
            if (busy) busy_late = 1'b1;
        end
        check("held_pulses", pulses, 2);
        check("held_first_latency", first_at, 2578);
        check("held_gap", second_at - first_at, 2578);
        check("held_restart_busy", busy_after, 1);
        check("held_idle_after", busy_late, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
